// File: rtl/vrf_elem_seq.sv
// Element sequencer in front of the single-port vector element SRAM.
// One SRAM access per element at wrapping addresses; a 2-entry buffer absorbs the read latency.
module vrf_elem_seq #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LEN_W  = 3
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_base_i,
    input  logic [LEN_W-1:0]  cmd_len_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sram_we_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);

    typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, last_addr_q, cur_addr;
    logic [LEN_W-1:0]  len_q, ocnt_q;
    logic [LEN_W:0]    idx_q;
    logic              inflight_q, rd_valid_q, done_q;
    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] buf0_q, buf1_q;
    logic              wr_fire, rd_issue, pop, push;
    logic [2:0]        occ, occ_limit;

    always_comb begin
        cmd_ready_o  = (state_q == StIdle);
        busy_o       = (state_q != StIdle);
        wr_ready_o   = (state_q == StWrite);
        wr_fire      = wr_ready_o && wr_valid_i;
        pop          = rd_valid_q && rd_ready_i;
        push         = inflight_q;
        occ          = {1'b0, count_q} + {2'b00, inflight_q};
        occ_limit    = 3'd2 + {2'b00, pop};
        // Issue only when a buffer slot is guaranteed for the returning element.
        rd_issue     = (state_q == StRead) && (idx_q <= {1'b0, len_q}) && (occ < occ_limit);
        cur_addr     = base_q + ADDR_W'(idx_q);
        sram_we_o    = wr_fire;
        sram_addr_o  = (wr_fire || rd_issue) ? cur_addr : last_addr_q;
        sram_wdata_o = wr_fire ? wr_data_i : '0;
        count_d      = count_q + {1'b0, push} - {1'b0, pop};
        rd_valid_o   = rd_valid_q;
        rd_data_o    = buf0_q;
        done_o       = done_q;

        state_d = state_q;
        case (state_q)
            StIdle:  if (cmd_valid_i) state_d = cmd_write_i ? StWrite : StRead;
            StWrite: if (wr_fire && (idx_q == {1'b0, len_q})) state_d = StDone;
            StRead:  if (pop && (ocnt_q == len_q)) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            ocnt_q      <= '0;
            last_addr_q <= '0;
            inflight_q  <= 1'b0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= (state_d == StDone);
            inflight_q <= rd_issue;
            count_q    <= count_d;
            rd_valid_q <= (count_d != 2'd0);
            if (cmd_ready_o && cmd_valid_i) begin
                base_q <= cmd_base_i;
                len_q  <= cmd_len_i;
                idx_q  <= '0;
                ocnt_q <= '0;
            end
            if (wr_fire || rd_issue) begin
                idx_q       <= idx_q + 1'b1;
                last_addr_q <= cur_addr;
            end
            if (pop) ocnt_q <= ocnt_q + 1'b1;
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) buf0_q <= sram_rdata_i;
                    else                 buf1_q <= sram_rdata_i;
                end
                2'b01: buf0_q <= buf1_q;
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf0_q <= sram_rdata_i;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= sram_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vrf_elem_seq.sv
// Scoreboard bench for vrf_elem_seq with a behavioural 32x32 registered-read SRAM.
module tb_vrf_elem_seq;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [4:0]  cmd_base = '0;
    logic [2:0]  cmd_len = '0;
    logic        wr_valid = 1'b0, wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid, rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        busy, done, sram_we;
    logic [4:0]  sram_addr;
    logic [31:0] sram_wdata, sram_rdata;

    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [4:0]  wa_q [$];
    logic [31:0] wd_q [$];
    logic [31:0] rq [$];
    int          n_vec = 0, n_err = 0, pop_cnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= sram_wdata;
        else         sram_rdata <= mem[sram_addr];
    end

    vrf_elem_seq dut (
        .clk          (clk),
        .nrst         (nrst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_write_i  (cmd_write),
        .cmd_base_i   (cmd_base),
        .cmd_len_i    (cmd_len),
        .wr_valid_i   (wr_valid),
        .wr_ready_o   (wr_ready),
        .wr_data_i    (wr_data),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rd_ready),
        .rd_data_o    (rd_data),
        .busy_o       (busy),
        .done_o       (done),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: compare every SRAM write and every delivered read element.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (sram_we) begin
                if (wa_q.size() == 0) begin
                    check("wr_unexpected", 32'(wa_q.size()), 32'd1);
                end else begin
                    check("wr_addr", 32'(sram_addr), 32'(wa_q.pop_front()));
                    check("wr_data", sram_wdata, wd_q.pop_front());
                end
            end
            if (rd_valid && rd_ready) begin
                pop_cnt++;
                if (rq.size() == 0) check("rd_unexpected", 32'(rq.size()), 32'd1);
                else                check("rd_data", rd_data, rq.pop_front());
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) check("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    task automatic issue_cmd(input logic wr, input logic [4:0] base, input logic [2:0] len);
        wait_idle();
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic write_vec(input logic [4:0] base, input logic [2:0] len,
                             input logic [31:0] dbase, input int gap);
        logic [4:0] a;
        issue_cmd(1'b1, base, len);
        for (int i = 0; i <= int'(len); i++) begin
            for (int g = 0; g < gap; g++) begin
                wr_valid = 1'b0;
                #2;
                check("we_gap", 32'(sram_we), 32'd0);
                @(posedge clk); #1;
            end
            a = base + 5'(i);
            wr_valid = 1'b1;
            wr_data  = dbase + 32'(i);
            wa_q.push_back(a);
            wd_q.push_back(wr_data);
            ref_mem[a] = wr_data;
            #2;
            check("we_hs", 32'(sram_we), 32'd1);
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check("wr_done", 32'(done), 32'd1);
        check("wr_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("wr_done_end", 32'(done), 32'd0);
        check("wr_busy_end", 32'(busy), 32'd0);
    endtask

    // mode 0: rd_ready held high with latency check; mode 1: ready pattern 1,0,0.
    task automatic read_vec(input logic [4:0] base, input logic [2:0] len,
                            input int mode, input int abort);
        int cyc = 0;
        logic [4:0] a;
        for (int i = 0; i <= int'(len); i++) begin
            a = base + 5'(i);
            rq.push_back(ref_mem[a]);
        end
        pop_cnt = 0;
        issue_cmd(1'b0, base, len);
        while (pop_cnt < int'(len) + 1 && cyc < 200 && !(abort > 0 && pop_cnt >= abort)) begin
            rd_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (mode == 0)
                check("rd_valid_t", 32'(rd_valid), 32'(cyc >= 2 && cyc <= int'(len) + 2));
            @(posedge clk); #1;
            cyc++;
        end
        if (abort > 0) begin
            nrst = 1'b0;
            #1;
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
            check("rst_delivered", 32'(pop_cnt), 32'(abort));
            rq.delete();
            @(posedge clk); #1;
            nrst = 1'b1;
            @(posedge clk); #1;
            return;
        end
        check("rd_count", 32'(pop_cnt), 32'(len) + 32'd1);
        check("rd_done", 32'(done), 32'd1);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_drained", 32'(rd_valid), 32'd0);
        rd_ready = 1'b0;
        @(posedge clk); #1;
        check("rd_done_end", 32'(done), 32'd0);
        check("rd_busy_end", 32'(busy), 32'd0);
        check("rd_left", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_we", 32'(sram_we), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_wdata", sram_wdata, 32'd0);
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;

        write_vec(5'd4, 3'd7, 32'h100, 0);
        check("addr_hold", 32'(sram_addr), 32'd11);
        read_vec(5'd4, 3'd7, 0, 0);
        write_vec(5'd30, 3'd3, 32'hA0, 0);
        read_vec(5'd30, 3'd3, 0, 0);
        read_vec(5'd4, 3'd7, 1, 0);
        write_vec(5'd16, 3'd2, 32'h200, 2);
        read_vec(5'd16, 3'd2, 1, 0);
        read_vec(5'd4, 3'd7, 0, 3);
        read_vec(5'd6, 3'd3, 0, 0);
        read_vec(5'd31, 3'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
